argmax_seq_ctrl: RTL and testbench

Sequential argmax scheduler for the classifier output stage. It accepts N class scores one per handshake from the final fully-connected layer and shares a single M-bit comparator across all of them, replacing a full comparator tree. It keeps a running max and index, then presents the winning class as a one-hot vector plus a binary index through a valid/ready output handshake.

---
 rtl/argmax_seq_ctrl_if.sv | 26 ++
 rtl/argmax_seq_ctrl.sv | 86 ++++++++
 tb/tb_argmax_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/argmax_seq_ctrl_if.sv
// Score-in / winner-out handshake bundle for the sequential argmax scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface argmax_seq_ctrl_if #(
   parameter int M  = 32,
   parameter int N  = 10,
   parameter int IW = $clog2(N)
);
   logic          in_valid;
   logic [M-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_onehot;
   logic [IW-1:0] out_index;
   logic [M-1:0]  out_max;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_onehot, out_index, out_max
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_onehot, out_index, out_max
   );
endinterface

// File: rtl/argmax_seq_ctrl.sv
// Sequential argmax: one shared comparator scans N scores per frame, keeping a
// running max/index, then offers the winner as one-hot + index + score.
module argmax_seq_ctrl #(
   parameter int M      = 32,
   parameter int N      = 10,
   parameter int SIGNED = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   argmax_seq_ctrl_if.slave  bus
);
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] count_q;
   logic [IW-1:0] idx_q;
   logic [N-1:0]  onehot_q;
   logic [M-1:0]  max_q;
   logic          accept;
   logic          gt;

   always_comb begin
      gt = 1'b0;
      if (SIGNED != 0) gt = $signed(bus.in_data) > $signed(max_q);
      else             gt = bus.in_data > max_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = ACCUM;
         end
         ACCUM: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            accept       = bus.in_valid;
            if (accept && count_q == LAST) state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            busy          = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result registers double as outputs; they only move on accepts, so they
   // are frozen through DONE and keep the last winner while IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q  <= '0;
         idx_q    <= '0;
         onehot_q <= '0;
         max_q    <= '0;
      end else if (state_q == IDLE && start) begin
         count_q <= '0;
      end else if (accept) begin
         count_q <= count_q + 1'b1;
         if (count_q == '0 || gt) begin
            max_q    <= bus.in_data;
            idx_q    <= count_q;
            onehot_q <= N'(1) << count_q;
         end
      end
   end

   assign bus.out_onehot = onehot_q;
   assign bus.out_index  = idx_q;
   assign bus.out_max    = max_q;
endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Directed bench for argmax_seq_ctrl: signed and unsigned instances share one
// stimulus stream; expected winners are hand-computed per scenario.
module tb_argmax_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;
   logic        busy_s, busy_u;
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned cyc = 0;
   int          scores [10];
   logic [9:0]  bubble_mask = 10'b0101100101;

   argmax_seq_ctrl_if #(.M(32), .N(10)) bs ();
   argmax_seq_ctrl_if #(.M(32), .N(10)) bu ();

   assign bs.in_valid  = in_valid;
   assign bs.in_data   = in_data;
   assign bs.out_ready = out_ready;
   assign bu.in_valid  = in_valid;
   assign bu.in_data   = in_data;
   assign bu.out_ready = out_ready;

   argmax_seq_ctrl #(.M(32), .N(10), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_s), .bus(bs));
   argmax_seq_ctrl #(.M(32), .N(10), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_u), .bus(bu));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse, ten beats (optionally with bubbles and stray starts), then
   // checks that the result appears exactly one cycle after the last beat.
   task automatic run_frame(input bit bub, output int unsigned start_cyc);
      start = 1'b1;
      tick();
      start_cyc = cyc;
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bub && bubble_mask[k]) begin
            in_valid = 1'b0;
            in_data  = 32'hDEAD_BEEF;
            start    = k[0];
            repeat ((k % 3) + 1) tick();
            start = 1'b0;
         end
         in_valid = 1'b1;
         in_data  = scores[k];
         vectors++;
         if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0) begin
            $display("FAIL beat_ready[%0d]: got in_ready=%b out_valid=%b, expected 1/0",
                     k, bs.in_ready, bs.out_valid);
            miscompares++;
         end
         tick();
      end
      in_valid = 1'b0;
      vectors++;
      if ({bs.out_valid, bs.in_ready, busy_s} !== 3'b101) begin
         $display("FAIL done_latency: got out_valid=%b in_ready=%b busy=%b, expected 1/0/1",
                  bs.out_valid, bs.in_ready, busy_s);
         miscompares++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_data = 32'd77;
      tick();
      tick();
      in_valid = 1'b0;
      vectors++;
      if ({bs.in_ready, bs.out_valid, bs.out_onehot, bs.out_index, bs.out_max, busy_s} !== '0 ||
          {bu.in_ready, bu.out_valid, bu.out_onehot, bu.out_index, bu.out_max, busy_u} !== '0) begin
         $display("FAIL reset_state: got rdy=%b v=%b oh=%b idx=%0d max=%h busy=%b, expected all 0",
                  bs.in_ready, bs.out_valid, bs.out_onehot, bs.out_index, bs.out_max, busy_s);
         miscompares++;
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int unsigned c;
      scores = '{5, 3, 9, 1, 0, 7, 2, 8, 4, 6};
      run_frame(1'b0, c);
      vectors++;
      if ({bs.out_index, bs.out_onehot, bs.out_max} !== {4'd2, 10'b0000000100, 32'd9}) begin
         $display("FAIL basic_result: got idx=%0d oh=%b max=%0d, expected idx=2 oh=0000000100 max=9",
                  bs.out_index, bs.out_onehot, bs.out_max);
         miscompares++;
      end
      handshake();
      vectors++;
      if ({bs.out_valid, busy_s, bs.out_index, bs.out_max} !== {1'b0, 1'b0, 4'd2, 32'd9}) begin
         $display("FAIL basic_release: got v=%b busy=%b idx=%0d max=%0d, expected v=0 busy=0 idx=2 max=9",
                  bs.out_valid, busy_s, bs.out_index, bs.out_max);
         miscompares++;
      end
   endtask

   task automatic test_signed();
      int unsigned c;
      scores = '{-5, -3, -9, -1, -100, -7, -2, -8, -4, -6};
      run_frame(1'b0, c);
      vectors++;
      if ({bs.out_index, bs.out_onehot, bs.out_max} !== {4'd3, 10'b0000001000, 32'hFFFF_FFFF}) begin
         $display("FAIL signed_result: got idx=%0d oh=%b max=%h, expected idx=3 oh=0000001000 max=ffffffff",
                  bs.out_index, bs.out_onehot, bs.out_max);
         miscompares++;
      end
      vectors++;
      if ({bu.out_valid, bu.out_index, bu.out_max} !== {1'b1, 4'd3, 32'hFFFF_FFFF}) begin
         $display("FAIL unsigned_result: got v=%b idx=%0d max=%h, expected v=1 idx=3 max=ffffffff",
                  bu.out_valid, bu.out_index, bu.out_max);
         miscompares++;
      end
      handshake();
   endtask

   task automatic test_ties();
      int unsigned c;
      scores = '{4, 7, 7, 2, 7, 0, 0, 0, 0, 0};
      run_frame(1'b0, c);
      vectors++;
      if ({bs.out_index, bs.out_onehot, bs.out_max} !== {4'd1, 10'b0000000010, 32'd7}) begin
         $display("FAIL ties_result: got idx=%0d oh=%b max=%0d, expected idx=1 oh=0000000010 max=7",
                  bs.out_index, bs.out_onehot, bs.out_max);
         miscompares++;
      end
      handshake();
   endtask

   task automatic test_bubbles();
      int unsigned c;
      scores = '{5, 3, 9, 1, 0, 7, 2, 8, 4, 6};
      run_frame(1'b1, c);
      for (int i = 0; i < 5; i++) begin
         start = i[0];
         tick();
         vectors++;
         if ({bs.out_valid, bs.out_index, bs.out_onehot, bs.out_max} !==
             {1'b1, 4'd2, 10'b0000000100, 32'd9}) begin
            $display("FAIL bubbles_hold[%0d]: got v=%b idx=%0d oh=%b max=%0d, expected v=1 idx=2 oh=0000000100 max=9",
                     i, bs.out_valid, bs.out_index, bs.out_onehot, bs.out_max);
            miscompares++;
         end
      end
      start = 1'b1;
      handshake();
      start = 1'b0;
      vectors++;
      if ({bs.out_valid, bs.in_ready, busy_s} !== 3'b000) begin
         $display("FAIL bubbles_start_ignored: got v=%b rdy=%b busy=%b, expected 0/0/0",
                  bs.out_valid, bs.in_ready, busy_s);
         miscompares++;
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int unsigned c;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 32'(k + 5);
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      vectors++;
      if ({bs.in_ready, bs.out_valid, bs.out_onehot, bs.out_index, bs.out_max, busy_s} !== '0) begin
         $display("FAIL midreset_state: got rdy=%b v=%b oh=%b idx=%0d max=%h busy=%b, expected all 0",
                  bs.in_ready, bs.out_valid, bs.out_onehot, bs.out_index, bs.out_max, busy_s);
         miscompares++;
      end
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data = 32'd99;
      tick();
      tick();
      in_valid = 1'b0;
      scores = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 11};
      run_frame(1'b0, c);
      vectors++;
      if ({bs.out_index, bs.out_onehot, bs.out_max} !== {4'd9, 10'b1000000000, 32'd11}) begin
         $display("FAIL midreset_fresh: got idx=%0d oh=%b max=%0d, expected idx=9 oh=1000000000 max=11",
                  bs.out_index, bs.out_onehot, bs.out_max);
         miscompares++;
      end
      handshake();
   endtask

   task automatic test_back_to_back();
      int unsigned c0, c1;
      scores = '{4, 7, 7, 2, 7, 0, 0, 0, 0, 0};
      run_frame(1'b0, c0);
      handshake();
      scores = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0};
      run_frame(1'b0, c1);
      vectors++;
      if ({bs.out_index, bs.out_onehot, bs.out_max} !== {4'd8, 10'b0100000000, 32'd3}) begin
         $display("FAIL b2b_result: got idx=%0d oh=%b max=%0d, expected idx=8 oh=0100000000 max=3",
                  bs.out_index, bs.out_onehot, bs.out_max);
         miscompares++;
      end
      vectors++;
      if (c1 - c0 !== 32'd12) begin
         $display("FAIL b2b_period: got %0d cycles, expected 12", c1 - c0);
         miscompares++;
      end
      handshake();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_signed();
      test_ties();
      test_bubbles();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
